// File: rtl/cache_refill.sv
// rtl/cache_refill.sv - refills one 1 KiB page into a 4-slot SRAM cache: invalidate tag, copy 1024 bytes, revalidate tag
// Optional macro CACHE_REFILL_CRITICAL_FIRST_EN: start the copy at the missed byte instead of offset 0
module cache_refill (
  input  logic        fpgaClk,
  input  logic        fpgaReset_n,
  input  logic        missReq,
  input  logic [13:0] missPage,
  input  logic [1:0]  missSlot,
  input  logic [9:0]  missOffset,
  output logic        missAck,
  output logic        busy,
  output logic        done,
  output logic        critReady,
  output logic [23:0] mem_addr,
  output logic        mem_rd,
  input  logic        mem_valid,
  input  logic [7:0]  mem_data,
  output logic [11:0] sram_addr,
  output logic        sram_we,
  output logic [7:0]  sram_wdata,
  output logic        tag_we,
  output logic [1:0]  tag_slot,
  output logic [13:0] tag_page,
  output logic        tag_valid
);

  typedef enum logic [2:0] {IDLE, INVAL, READ, WRITE, TAG, DONE} state_t;

  state_t      state;
  logic [13:0] page_q;
  logic [1:0]  slot_q;
  logic [9:0]  miss_off_q;
  logic [9:0]  offset;
  logic [10:0] count;
  logic [9:0]  start_off;
  logic        crit_hit;

`ifdef CACHE_REFILL_CRITICAL_FIRST_EN
  assign start_off = missOffset;
`else
  assign start_off = 10'd0;
`endif

  // The offset visits every value exactly once, so this matches once per refill
  // (on the first byte when the copy starts at the missed offset).
  assign crit_hit  = (offset == miss_off_q);

  assign missAck   = (state == IDLE) && missReq;
  assign mem_addr  = {page_q, offset};
  assign sram_addr = {slot_q, offset};
  assign tag_slot  = slot_q;
  assign tag_page  = page_q;

  always_ff @(posedge fpgaClk or negedge fpgaReset_n) begin
    if (!fpgaReset_n) begin
      state      <= IDLE;
      page_q     <= '0;
      slot_q     <= '0;
      miss_off_q <= '0;
      offset     <= '0;
      count      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      critReady  <= 1'b0;
      mem_rd     <= 1'b0;
      sram_we    <= 1'b0;
      sram_wdata <= '0;
      tag_we     <= 1'b0;
      tag_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (missReq) begin
            page_q     <= missPage;
            slot_q     <= missSlot;
            miss_off_q <= missOffset;
            offset     <= start_off;
            count      <= '0;
            busy       <= 1'b1;
            tag_we     <= 1'b1;
            tag_valid  <= 1'b0;
            state      <= INVAL;
          end
        end
        INVAL: begin
          tag_we <= 1'b0;
          mem_rd <= 1'b1;
          state  <= READ;
        end
        READ: begin
          if (mem_valid) begin
            mem_rd     <= 1'b0;
            sram_we    <= 1'b1;
            sram_wdata <= mem_data;
            critReady  <= crit_hit;
            state      <= WRITE;
          end
        end
        WRITE: begin
          sram_we   <= 1'b0;
          critReady <= 1'b0;
          offset    <= offset + 10'd1;
          count     <= count + 11'd1;
          // The byte count, not the wrapping offset, ends the transfer.
          if (count == 11'd1023) begin
            tag_we    <= 1'b1;
            tag_valid <= 1'b1;
            state     <= TAG;
          end else begin
            mem_rd <= 1'b1;
            state  <= READ;
          end
        end
        TAG: begin
          tag_we <= 1'b0;
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_refill.sv
// tb/tb_cache_refill.sv - self-checking bench for cache_refill: refill sequence model plus directed timing/boundary checks
module tb_cache_refill;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        missReq = 1'b0;
  logic [13:0] missPage = '0;
  logic [1:0]  missSlot = '0;
  logic [9:0]  missOffset = '0;
  logic        missAck, busy, done, critReady;
  logic [23:0] mem_addr;
  logic        mem_rd;
  logic        mem_valid = 1'b0;
  logic [7:0]  mem_data;
  logic [11:0] sram_addr;
  logic        sram_we;
  logic [7:0]  sram_wdata;
  logic        tag_we;
  logic [1:0]  tag_slot;
  logic [13:0] tag_page;
  logic        tag_valid;

  cache_refill dut (
    .fpgaClk(clk), .fpgaReset_n(rst_n),
    .missReq(missReq), .missPage(missPage), .missSlot(missSlot), .missOffset(missOffset),
    .missAck(missAck), .busy(busy), .done(done), .critReady(critReady),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_valid(mem_valid), .mem_data(mem_data),
    .sram_addr(sram_addr), .sram_we(sram_we), .sram_wdata(sram_wdata),
    .tag_we(tag_we), .tag_slot(tag_slot), .tag_page(tag_page), .tag_valid(tag_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Backing memory contents are a fixed function of the address.
  function automatic logic [7:0] pat(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h3C;
  endfunction
  assign mem_data = pat(mem_addr);

  // Memory responder: valid together with the read (fast) or on the 4th read cycle (slow).
  bit slow_mode = 1'b0;
  int rd_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (!slow_mode) mem_valid = 1'b1;
    else if (mem_rd) begin
      rd_cnt++;
      mem_valid = (rd_cnt == 4);
    end else begin
      rd_cnt = 0;
      mem_valid = 1'b0;
    end
  end

  // Refill model: phase 0 idle, 1 invalidate, 2 byte copy, 3 revalidate, 4 done pulse.
  int          phase = 0;
  bit          m_busy = 1'b0;
  logic [13:0] m_page = '0;
  logic [1:0]  m_slot = '0;
  logic [9:0]  m_miss = '0;
  logic [9:0]  exp_off = '0;
  int          nwr = 0;
  int          cyc = 0, acc_cyc = 0, done_cyc = 0, crit_idx = -1, w0_cyc = 0, w1_cyc = 0, tagv_seen = 0;
  logic [11:0] first_waddr = '0, last_waddr = '0;
  logic [23:0] first_raddr = '0, last_raddr = '0;
  bit          first_rd = 1'b0;

  always @(negedge clk) begin
    bit acc;
    cyc++;
    if (!rst_n) begin
      check("rst_ctl", {busy, done, critReady, mem_rd, sram_we, tag_we, tag_valid}, 0);
      check("rst_addr", {mem_addr, sram_addr}, 0);
      check("rst_data", {sram_wdata, tag_slot, tag_page}, 0);
      phase = 0;
      m_busy = 1'b0;
    end else begin
      acc = missReq && !m_busy;
      check("missAck", missAck, acc);
      check("busy", busy, m_busy);
      if (tag_we) begin
        if (phase == 1) begin
          check("inval_tag", {tag_valid, tag_slot}, {1'b0, m_slot});
          phase = 2;
        end else if (phase == 3) begin
          check("valid_tag", {tag_valid, tag_slot, tag_page}, {1'b1, m_slot, m_page});
          tagv_seen++;
          phase = 4;
        end else begin
          check("tag_we_unexpected", tag_we, 0);
          if (tag_valid) tagv_seen++;
        end
      end
      if (mem_rd) begin
        check("mem_addr", mem_addr, {m_page, exp_off});
        if (first_rd) begin first_raddr = mem_addr; first_rd = 1'b0; end
        last_raddr = mem_addr;
      end
      if (sram_we) begin
        check("wr_phase", phase, 2);
        check("sram_addr", sram_addr, {m_slot, exp_off});
        check("sram_wdata", sram_wdata, pat({m_page, exp_off}));
        check("critReady", critReady, exp_off == m_miss);
        if (nwr == 0) begin first_waddr = sram_addr; w0_cyc = cyc; end
        if (nwr == 1) w1_cyc = cyc;
        if (critReady) crit_idx = nwr;
        last_waddr = sram_addr;
        exp_off = exp_off + 10'd1;
        nwr++;
        if (nwr == 1024) phase = 3;
      end else begin
        check("crit_idle", critReady, 0);
      end
      if (done) begin
        check("done_phase", phase, 4);
        check("done_nwr", nwr, 1024);
        done_cyc = cyc;
        phase = 0;
        m_busy = 1'b0;
      end else if (acc) begin
        m_page = missPage;
        m_slot = missSlot;
        m_miss = missOffset;
`ifdef CACHE_REFILL_CRITICAL_FIRST_EN
        exp_off = missOffset;
`else
        exp_off = 10'd0;
`endif
        nwr = 0;
        crit_idx = -1;
        first_rd = 1'b1;
        acc_cyc = cyc;
        phase = 1;
        m_busy = 1'b1;
      end
    end
  end

  task automatic request(input logic [13:0] p, input logic [1:0] s, input logic [9:0] o);
    int n = 0;
    @(posedge clk); #1;
    missReq = 1'b1; missPage = p; missSlot = s; missOffset = o;
    do begin @(negedge clk); n++; end while (!missAck && n < 8000);
    check("ack_wait", missAck, 1);
    @(posedge clk); #1;
    missReq = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    do begin @(negedge clk); n++; end while (!done && n < budget);
    check("done_wait", done, 1);
    #1;
  endtask

  task automatic run_offset(input logic [1:0] s, input logic [9:0] o, input logic [11:0] fw,
                            input logic [11:0] lw, input int ci);
    request(14'h0007, s, o);
    wait_done(2200);
    check("first_waddr", first_waddr, fw);
    check("last_waddr", last_waddr, lw);
    check("crit_idx", crit_idx, ci);
  endtask

  initial begin
    int n, ack2_cyc, tv;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Fast memory: page 5 into slot 2 from offset 0.
    request(14'h0005, 2'd2, 10'h000);
    wait_done(2200);
    check("refill_cycles", done_cyc - acc_cyc, 2051);
    check("first_waddr", first_waddr, 12'h800);
    check("last_waddr", last_waddr, 12'hBFF);
    check("first_raddr", first_raddr, 24'h001400);
    check("last_raddr", last_raddr, 24'h0017FF);
    check("crit_idx0", crit_idx, 0);
    check("tagv_count", tagv_seen, 1);

    // Slow memory: 5 cycles per byte.
    slow_mode = 1'b1;
    request(14'h2A3C, 2'd1, 10'h155);
    wait_done(6000);
    check("byte_period", w1_cyc - w0_cyc, 5);
    check("slow_cycles", done_cyc - acc_cyc, 5123);
`ifdef CACHE_REFILL_CRITICAL_FIRST_EN
    check("slow_crit", crit_idx, 0);
`else
    check("slow_crit", crit_idx, 341);
`endif
    slow_mode = 1'b0;

    // Offsets near the wrap and mid-page.
`ifdef CACHE_REFILL_CRITICAL_FIRST_EN
    run_offset(2'd3, 10'h3FE, 12'hFFE, 12'hFFD, 0);
    run_offset(2'd0, 10'h200, 12'h200, 12'h1FF, 0);
`else
    run_offset(2'd3, 10'h3FE, 12'hC00, 12'hFFF, 1022);
    run_offset(2'd0, 10'h200, 12'h000, 12'h3FF, 512);
`endif

    // Second request held high through a refill.
    request(14'h0011, 2'd1, 10'h000);
    @(posedge clk); #1;
    missReq = 1'b1; missPage = 14'h0022; missSlot = 2'd3; missOffset = 10'h001;
    wait_done(2200);
    n = 0;
    do begin @(negedge clk); n++; end while (!missAck && n < 20);
    #1;
    ack2_cyc = cyc;
    check("ack_after_done", ack2_cyc - done_cyc, 1);
    @(posedge clk); #1;
    missReq = 1'b0;
    wait_done(2200);
    check("held_req_page", tag_page, 14'h0022);

    // Reset during byte 100.
    tv = tagv_seen;
    request(14'h0009, 2'd1, 10'h010);
    n = 0;
    do begin @(negedge clk); n++; end while (nwr < 100 && n < 400);
    check("reached_byte100", nwr >= 100, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_ctl", {done, critReady, mem_rd, sram_we, tag_we, tag_valid}, 0);
    check("abort_addr", {mem_addr, sram_addr}, 0);
    check("abort_data", {sram_wdata, tag_slot, tag_page}, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (30) @(negedge clk);
    #1;
    check("abort_no_valid_tag", tagv_seen - tv, 0);
    check("idle_after_abort", busy, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/cache_refill.md
CACHE_REFILL -- requirements
Module: cache_refill

Interface
REQ-001 Parameters: none; page = 1 KiB (10-bit offset), 4 cache slots, 24-bit bus address, all fixed.
REQ-002 fpgaClk  in  1  single system clock; all state changes on its rising edge.
REQ-003 fpgaReset_n  in  1  reset, asynchronous assert, active-low.
REQ-004 missReq  in  1  refill request; held high by requester until missAck.
REQ-005 missPage  in  14  page number (address bits 23:10) to load.
REQ-006 missSlot  in  2  victim slot to overwrite.
REQ-007 missOffset  in  10  offset of the byte that caused the miss.
REQ-008 missAck  out  1  combinational; high when state is IDLE and missReq is high.
REQ-009 busy  out  1  high in every state except IDLE.
REQ-010 done  out  1  one-cycle pulse in state DONE.
REQ-011 critReady  out  1  one-cycle pulse when the byte at the latched missOffset is written to SRAM.
REQ-012 mem_addr  out  24  backing-memory read address: {latched page, current offset}.
REQ-013 mem_rd  out  1  read strobe to backing memory.
REQ-014 mem_valid  in  1  read data valid; meaningful only while mem_rd is high.
REQ-015 mem_data  in  8  read data.
REQ-016 sram_addr  out  12  SRAM write address: {latched slot, current offset}.
REQ-017 sram_we  out  1  SRAM write enable.
REQ-018 sram_wdata  out  8  SRAM write data.
REQ-019 tag_we  out  1  tag-table write strobe.
REQ-020 tag_slot  out  2  tag entry index (the latched slot).
REQ-021 tag_page  out  14  tag value (the latched page).
REQ-022 tag_valid  out  1  valid bit written with the tag.

Function
REQ-023 States: IDLE, INVAL, READ, WRITE, TAG, DONE.
REQ-024 IDLE: if missReq=1, latch missPage, missSlot and missOffset, load the offset counter with its start value, and go to INVAL. Otherwise remain in IDLE.
REQ-025 While not IDLE, missReq is ignored and missAck stays low; a request held high through DONE is accepted in the next IDLE cycle.
REQ-026 INVAL: assert tag_we=1 with tag_valid=0 for one cycle, then go to READ.
REQ-027 READ: mem_rd=1 and mem_addr stable. If mem_valid=1, capture mem_data and go to WRITE; otherwise remain in READ. There is no timeout.
REQ-028 WRITE: mem_rd=0; sram_we=1 for one cycle with the captured byte and current offset. Then increment the offset modulo 1024 and the byte count. Go to TAG after the 1024th byte, else go to READ.
REQ-029 TAG: assert tag_we=1 with tag_valid=1 for one cycle, then go to DONE.
REQ-030 DONE: done=1 for one cycle, then go to IDLE.
REQ-031 Each byte takes at least 2 cycles. With mem_valid tied high, a refill takes 2051 cycles from the accepting edge to done.
REQ-032 Offset wraps from 1023 to 0. The byte count (11 bits) terminates the transfer, not the offset value.
REQ-033 tag_slot and tag_page are driven from the latched values at all times outside reset.

Reset
REQ-034 Asserting fpgaReset_n low, at any time, forces IDLE and drives every registered output to 0 (mem_addr, sram_addr, sram_wdata, tag_slot, tag_page, the latches and the counters included).
REQ-035 Reset during a refill aborts it with no further tag_we. A slot already invalidated in INVAL stays invalid.

Configuration
REQ-036 Macro CACHE_REFILL_CRITICAL_FIRST_EN.
- Defined: the offset counter starts at missOffset, so the missed byte is fetched first. critReady pulses in the first WRITE cycle.
- Undefined: the counter starts at 0 and critReady pulses in the WRITE cycle where offset equals the latched missOffset.
- In both cases exactly 1024 bytes are written, once each.

Verification
REQ-037 mem_valid tied high, missReq with page 0x0005, slot 2, offset 0; release reset → one tag_we (slot 2, valid=0) → 1024 writes to sram_addr 0x800..0xBFF with mem_addr 0x001400..0x0017FF → tag_we (page 0x0005, valid=1) → done at accept edge +2051.
REQ-038 mem_valid asserted 3 cycles after each mem_rd rise → mem_rd holds with addr stable; each byte takes 5 cycles; data written matches mem_data.
REQ-039 Macro defined, offset 0x3FE → writes at offsets 0x3FE, 0x3FF, 0x000 … 0x3FD; critReady in the first WRITE; total 1024 writes.
REQ-040 Macro undefined, offset 0x200 → critReady exactly in the WRITE with sram_addr offset 0x200 (513th write).
REQ-041 Second missReq held during a refill → no missAck until IDLE; accepted the cycle after done.
REQ-042 Reset asserted at byte 100 → all outputs 0 immediately; busy=0; no valid=1 tag_we observed.
